// File: rtl/snowbro2_eeprom.sv
// 93C46-style serial EEPROM responder (64x16) with optional host load/save port.
// Optional host port enabled by defining SNOWBRO2_EEPROM_HOST_EN.
module snowbro2_eeprom #(
  parameter int BUSY_CYCLES = 4800
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SCS,
  input  logic        SCLK,
  input  logic        SDI,
  output logic        SDO,
  output logic        BUSY,
  input  logic [5:0]  HOST_ADDR,
  input  logic [15:0] HOST_DIN,
  input  logic        HOST_WE,
  output logic [15:0] HOST_DOUT
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] OPC    = 3'd1;
  localparam logic [2:0] ADDR   = 3'd2;
  localparam logic [2:0] RDUMMY = 3'd3;
  localparam logic [2:0] RDATA  = 3'd4;
  localparam logic [2:0] WDATA  = 3'd5;
  localparam logic [2:0] ARMED  = 3'd6;
  localparam logic [2:0] PROG   = 3'd7;

  localparam logic [15:0] BUSY_LOAD = 16'(BUSY_CYCLES - 1);

  logic [2:0]  cs_sh, ck_sh, di_sh;
  logic        cs, di, rise, cs_fall;
  logic [2:0]  state;
  logic [4:0]  cnt;
  logic [7:0]  cmd, nxt_cmd;
  logic [5:0]  addr;
  logic [15:0] rd_sh, wr_dat;
  logic        op_all, wen;
  logic [15:0] busy_cnt;
  logic [6:0]  pidx;
  logic        sdo, busy;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [15:0] mem [64];

  // [1] is the synchronized level, [2] the history bit for edge detection
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cs_sh <= '0;
      ck_sh <= '0;
      di_sh <= '0;
    end else begin
      cs_sh <= {cs_sh[1:0], SCS};
      ck_sh <= {ck_sh[1:0], SCLK};
      di_sh <= {di_sh[1:0], SDI};
    end
  end

  assign cs      = cs_sh[1];
  assign di      = di_sh[1];
  assign rise    = ck_sh[1] & ~ck_sh[2];
  assign cs_fall = ~cs_sh[1] & cs_sh[2];
  assign nxt_cmd = {cmd[6:0], di};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      cmd      <= '0;
      addr     <= '0;
      rd_sh    <= '0;
      wr_dat   <= '0;
      op_all   <= 1'b0;
      wen      <= 1'b0;
      busy_cnt <= '0;
      pidx     <= '0;
      sdo      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sdo <= 1'b1;
          if (cs && rise && di) begin
            state <= OPC;
            cnt   <= '0;
          end
        end
        OPC: begin
          if (cs_fall) begin
            state <= IDLE;
            sdo   <= 1'b1;
          end else if (rise) begin
            cmd <= nxt_cmd;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd1) begin
              state <= ADDR;
              cnt   <= '0;
            end
          end
        end
        ADDR: begin
          if (cs_fall) begin
            state <= IDLE;
            sdo   <= 1'b1;
          end else if (rise) begin
            cmd <= nxt_cmd;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd5) begin
              addr <= nxt_cmd[5:0];
              cnt  <= '0;
              case (nxt_cmd[7:6])
                2'b10: begin
                  state <= RDUMMY;
                  rd_sh <= mem[nxt_cmd[5:0]];
                  sdo   <= 1'b0;
                end
                2'b01: begin
                  state  <= WDATA;
                  op_all <= 1'b0;
                end
                2'b11: begin
                  state  <= ARMED;
                  op_all <= 1'b0;
                  wr_dat <= 16'hFFFF;
                end
                default: begin
                  case (nxt_cmd[5:4])
                    2'b01: begin
                      state  <= WDATA;
                      op_all <= 1'b1;
                    end
                    2'b10: begin
                      state  <= ARMED;
                      op_all <= 1'b1;
                      wr_dat <= 16'hFFFF;
                    end
                    2'b11: begin
                      state <= IDLE;
                      wen   <= 1'b1;
                    end
                    default: begin
                      state <= IDLE;
                      wen   <= 1'b0;
                    end
                  endcase
                end
              endcase
            end
          end
        end
        RDUMMY: begin
          if (cs_fall) begin
            state <= IDLE;
            sdo   <= 1'b1;
          end else if (rise) begin
            state <= RDATA;
            sdo   <= rd_sh[15];
            rd_sh <= {rd_sh[14:0], 1'b0};
            cnt   <= 5'd1;
          end
        end
        RDATA: begin
          if (cs_fall) begin
            state <= IDLE;
            sdo   <= 1'b1;
          end else if (rise) begin
            // after the last data bit, park on the ready level until CS drops
            if (cnt == 5'd16) begin
              sdo <= 1'b1;
            end else begin
              sdo   <= rd_sh[15];
              rd_sh <= {rd_sh[14:0], 1'b0};
              cnt   <= cnt + 5'd1;
            end
          end
        end
        WDATA: begin
          if (cs_fall) begin
            state <= IDLE;
            sdo   <= 1'b1;
          end else if (rise) begin
            wr_dat <= {wr_dat[14:0], di};
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd15) state <= ARMED;
          end
        end
        ARMED: begin
          sdo <= 1'b1;
          if (cs_fall) begin
            if (wen) begin
              state    <= PROG;
              busy     <= 1'b1;
              busy_cnt <= BUSY_LOAD;
              pidx     <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          sdo      <= ~cs;
          busy_cnt <= busy_cnt - 16'd1;
          if (pidx != 7'd64) pidx <= pidx + 7'd1;
          if (busy_cnt == 16'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            sdo   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign prog_we   = (state == PROG) && (op_all ? (pidx < 7'd64) : (pidx == 7'd0));
  assign prog_addr = op_all ? pidx[5:0] : addr;

  // the PROG write is issued last so it wins a same-word collision with the host
  always_ff @(posedge CLK) begin
`ifdef SNOWBRO2_EEPROM_HOST_EN
    if (HOST_WE) mem[HOST_ADDR] <= HOST_DIN;
`endif
    if (prog_we) mem[prog_addr] <= wr_dat;
  end

`ifdef SNOWBRO2_EEPROM_HOST_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) HOST_DOUT <= '0;
    else       HOST_DOUT <= mem[HOST_ADDR];
  end
`else
  logic host_unused;
  assign host_unused = ^{HOST_ADDR, HOST_DIN, HOST_WE};
  assign HOST_DOUT   = '0;
`endif

  assign SDO  = sdo;
  assign BUSY = busy;

endmodule
